pokemon_irq_ctrl: RTL and testbench
===================================

// Module: pokemon_irq_ctrl
// PURPOSE
//  Interrupt aggregator downstream of the interval timer and other peripheral irq lines.
//  Sits between the peripherals and the Nios II irq input, behind an Avalon-MM slave.
//  Synchronises each source, latches it as pending (edge or level), masks it, and drives
//  one registered irq plus the highest-priority source ID. Lowest index = highest priority.
// PARAMETERS
//  NUM_SRC      8  number of irq sources, legal 1..15; timer_0 irq wires to bit 0
//  SYNC_STAGES  2  flops in each source synchroniser, legal 1..3
// PORTS
//  clk         in   1        system clock
//  reset_n     in   1        asynchronous active-low reset
//  irq_src     in   NUM_SRC  raw peripheral irq lines, active high
//  address     in   3        Avalon word address
//  chipselect  in   1        Avalon select
//  write_n     in   1        Avalon write strobe, active low
//  writedata   in   16       Avalon write data
//  readdata    out  16       Avalon read data, registered
//  irq         out  1        combined interrupt to the CPU, registered
//  irq_id      out  4        index of the highest-priority active source; 4'hF = none
// BEHAVIOUR
//  Register map. Unused bits read 0; writes to other addresses are ignored.
//   0 PENDING: read. Write-1-to-clear.
//   1 MASK: read/write. A 1 enables the source.
//   2 EDGE: read/write. 1 = rising-edge latched, 0 = level.
//   3 ACTIVE: read only. PENDING & MASK.
//   4 ID: read only. bit15 = any active, [3:0] = irq_id.
//   5 FORCE: write 1s to set PENDING bits (software trigger). Reads 0.
//   6 COUNT: see CONFIGURATION.
//  Reset values: all registers, sync flops and edge-history flops = 0; readdata = 0; irq = 0; irq_id = 4'hF.
//  Sync: irq_src passes through SYNC_STAGES flops to give s. prev <= s every cycle.
//  Set condition per bit: EDGE=1 -> s & ~prev; EDGE=0 -> s; or a FORCE write with a 1 in that bit.
//  Clear condition: write to 0 with writedata[i]=1.
//  Simultaneous set and clear in one cycle: set wins. A level source held high therefore
//   cannot be cleared until it deasserts.
//  Edge history runs regardless of MASK. An edge while masked still sets PENDING.
//  irq <= |(PENDING & MASK). irq_id <= lowest set index of PENDING & MASK, else 4'hF.
//  Latency: irq_src rise -> PENDING set after SYNC_STAGES+1 clocks -> irq one clock later.
//   With the default that is 4 clocks, edge to irq.
//  W1C or MASK clear -> irq drops one clock after the write cycle.
//  Reads: readdata <= mux(address) every cycle. Data is valid the cycle after address is presented.
//   Reads have no side effects.
//  Changing EDGE does not alter PENDING. Going from level to edge needs a new rising edge to set again.
//  Reset asserted mid-operation clears all state immediately. No irq is generated on release
//   even if sources are high in edge mode, because prev syncs with s.
// CONFIGURATION
//  IRQ_CTRL_COUNT_EN defined: 16-bit event counter at address 6.
//   - Increments by 1 in any cycle where at least one PENDING bit goes 0 -> 1.
//   - Saturates at 16'hFFFF.
//   - Any write to address 6 clears it to 0. Clear wins over increment.
//   - Reset value 0.
//  IRQ_CTRL_COUNT_EN undefined: no counter logic; address 6 reads 0 and writes are ignored.
// TESTING
//  1. Edge, timer irq: MASK=0x0001, EDGE=0x0001, pulse irq_src[0] for 1 clk -> irq=1 four clocks later;
//     ID reads 0x8000. Write 0x0001 to addr 0 -> irq=0 next clk; PENDING reads 0.
//  2. Priority: MASK=0x00FF, src2 and src5 rise together -> irq_id=2, ID=0x8002.
//     W1C 0x0004 -> irq_id=5, irq stays 1.
//  3. Level: EDGE=0, MASK=0x0008, hold src3 high, W1C 0x0008 -> PENDING[3] stays 1.
//     Drop src3, wait 3 clks, W1C -> PENDING=0, irq=0, irq_id=4'hF.
//  4. Mask: MASK=0, edge on src1 -> PENDING=0x0002, irq=0.
//     Write MASK=0x0002 -> irq=1 one clock after the write.
//  5. Force and count: write FORCE=0x0010 then FORCE=0x0030 -> PENDING=0x0030.
//     COUNT=2 with IRQ_CTRL_COUNT_EN; 0 without. Simultaneous FORCE+W1C on bit 4 -> bit 4 stays 1.
//  6. Reset mid-operation: with irq=1 and src0 high in edge mode, pulse reset_n low ->
//     irq=0, irq_id=4'hF, all regs 0. No irq after release.

Source files
------------

// File: rtl/pokemon_irq_ctrl.sv
// ---------------------------------------------------------------------------
// pokemon_irq_ctrl
//
// Interrupt aggregator for the Nios II irq input. Each raw peripheral line is
// synchronised, then latched into PENDING on a rising edge or on a high level,
// depending on its EDGE bit. The pending sources that MASK enables are
// combined into one registered irq. irq_id reports the index of the
// highest-priority enabled source; index 0 (timer_0) has the highest priority.
// An Avalon-MM slave gives access to the register file.
//
// Register map (word address):
//   0 PENDING  read, write-1-to-clear
//   1 MASK     read/write, 1 = source enabled
//   2 EDGE     read/write, 1 = rising-edge latched, 0 = level
//   3 ACTIVE   read only, PENDING & MASK
//   4 ID       read only, bit15 = any active, [3:0] = irq_id
//   5 FORCE    write 1s to set PENDING bits, reads 0
//   6 COUNT    pending-event counter (optional), else reads 0
//
// Optional feature macro: IRQ_CTRL_COUNT_EN
//   defined   -> 16-bit saturating counter at address 6. It increments in any
//                cycle where a PENDING bit goes 0->1. Any write to address 6
//                clears it, and the clear wins over an increment.
//   undefined -> no counter; address 6 reads 0 and writes are ignored.
//
// Parameters:
//   NUM_SRC      number of irq sources (1..15)
//   SYNC_STAGES  synchroniser depth per source (1..3)
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   irq_src     raw peripheral irq lines, active high
//   address     Avalon word address
//   chipselect  Avalon select
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   readdata    Avalon read data, registered (valid the cycle after address)
//   irq         combined interrupt to the CPU, registered
//   irq_id      highest-priority active source index, 4'hF = none
// ---------------------------------------------------------------------------
module pokemon_irq_ctrl #(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq,
    output logic [3:0]         irq_id
);

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_edge;
    logic [15:0]        r_readdata;
    logic               r_irq;
    logic [3:0]         r_irq_id;

    logic               w_wr;
    logic [NUM_SRC-1:0] w_wdata;
    logic [NUM_SRC-1:0] w_s;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_force;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_active;
    logic [3:0]         w_id;
    logic [15:0]        w_count;
    logic [15:0]        w_rd;
    logic               w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wdata  = writedata[NUM_SRC-1:0];
    assign w_unused = &{1'b0, writedata};
    assign w_s      = r_sync[SYNC_STAGES-1];

    assign w_force = (w_wr && address == 3'd5) ? w_wdata : '0;
    assign w_clr   = (w_wr && address == 3'd0) ? w_wdata : '0;

    // Edge sources latch only on a new rising edge; level sources latch
    // whenever high. Set is ORed in after the clear so that set wins.
    assign w_set          = (r_edge & w_s & ~r_prev) | (~r_edge & w_s) | w_force;
    assign w_pending_next = (r_pending & ~w_clr) | w_set;
    assign w_active       = r_pending & r_mask;

    // Lowest index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        w_id = 4'hF;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id = 4'(i);
            end
        end
    end

    // Synchroniser chain and edge history. Edge history runs whatever
    // MASK holds, so a masked edge still latches into PENDING.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= irq_src;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_edge    <= '0;
            r_irq     <= 1'b0;
            r_irq_id  <= 4'hF;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr && address == 3'd1) begin
                r_mask <= w_wdata;
            end
            if (w_wr && address == 3'd2) begin
                r_edge <= w_wdata;
            end
            r_irq    <= |w_active;
            r_irq_id <= w_id;
        end
    end

`ifdef IRQ_CTRL_COUNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 16'h0000;
        end else if (w_wr && address == 3'd6) begin
            r_count <= 16'h0000;
        end else if ((|(w_pending_next & ~r_pending)) && r_count != 16'hFFFF) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign w_count = r_count;
`else
    assign w_count = 16'h0000;
`endif

    // The ID register reports the registered irq/irq_id outputs, so it
    // always agrees with what the CPU sees on the irq pins.
    always_comb begin
        w_rd = 16'h0000;
        case (address)
            3'd0:    w_rd = 16'(r_pending);
            3'd1:    w_rd = 16'(r_mask);
            3'd2:    w_rd = 16'(r_edge);
            3'd3:    w_rd = 16'(w_active);
            3'd4:    w_rd = {r_irq, 11'b0, r_irq_id};
            3'd6:    w_rd = w_count;
            default: w_rd = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 16'h0000;
        end else begin
            r_readdata <= w_rd;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;
    assign irq_id   = r_irq_id;

endmodule

// File: tb/tb_pokemon_irq_ctrl.sv
module tb_pokemon_irq_ctrl;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam logic [15:0] LM = 16'((1 << N) - 1);
`ifdef IRQ_CTRL_COUNT_EN
    localparam logic [15:0] CNT_AFTER_TWO = 16'd2;
`else
    localparam logic [15:0] CNT_AFTER_TWO = 16'd0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic [2:0]    address = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [15:0]   writedata = 16'h0000;
    logic [15:0]   readdata;
    logic          irq;
    logic [3:0]    irq_id;

    pokemon_irq_ctrl #(.NUM_SRC(N), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_src    (irq_src),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_id     (irq_id)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_pend, m_mask, m_edge, m_cnt, m_prev;
    logic [15:0] m_sq[$];
    logic        m_irq;
    logic [3:0]  m_id;

    logic [15:0] sb[$];
    logic        rd_seen = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_edge = 0; m_cnt = 0; m_prev = 0;
        m_irq = 1'b0; m_id = 4'hF;
        m_sq.delete();
        for (int i = 0; i < SS; i++) m_sq.push_back(16'h0000);
    endtask

    // One clock of stimulus. Computes the model's next state from the
    // inputs currently applied, queues the expected read data, and commits
    // the model on the clock edge.
    task automatic tick(input bit use_const, input logic [15:0] cexp);
        logic [15:0] s, set, clr, frc, pn, act, rd_n, mask_n, edge_n, cnt_n;
        logic        wr, irq_n;
        logic [3:0]  id_n;
        s = 0; pn = 0; mask_n = 0; edge_n = 0; cnt_n = 0; irq_n = 0; id_n = 4'hF;
        if (reset_n) begin
            s  = m_sq[0];
            wr = chipselect && !write_n;
            set = 0;
            for (int i = 0; i < N; i++) begin
                if (m_edge[i]) set[i] = s[i] && !m_prev[i];
                else           set[i] = s[i];
            end
            frc = (wr && address == 3'd5) ? (writedata & LM) : 16'h0;
            clr = (wr && address == 3'd0) ? (writedata & LM) : 16'h0;
            pn  = (m_pend & ~clr) | set | frc;
            act = m_pend & m_mask;
            irq_n = (act != 0);
            id_n  = 4'hF;
            for (int i = 0; i < N; i++) begin
                if (act[i] && id_n == 4'hF) id_n = 4'(i);
            end
            case (address)
                3'd0: rd_n = m_pend;
                3'd1: rd_n = m_mask;
                3'd2: rd_n = m_edge;
                3'd3: rd_n = act;
                3'd4: rd_n = {m_irq, 11'b0, m_id};
`ifdef IRQ_CTRL_COUNT_EN
                3'd6: rd_n = m_cnt;
`endif
                default: rd_n = 16'h0;
            endcase
            mask_n = (wr && address == 3'd1) ? (writedata & LM) : m_mask;
            edge_n = (wr && address == 3'd2) ? (writedata & LM) : m_edge;
`ifdef IRQ_CTRL_COUNT_EN
            if (wr && address == 3'd6) cnt_n = 0;
            else if ((pn & ~m_pend) != 0 && m_cnt != 16'hFFFF) cnt_n = m_cnt + 1;
            else cnt_n = m_cnt;
`else
            cnt_n = 0;
`endif
            if (chipselect && write_n) sb.push_back(use_const ? cexp : rd_n);
        end
        @(posedge clk);
        if (reset_n) begin
            m_pend = pn; m_mask = mask_n; m_edge = edge_n; m_cnt = cnt_n;
            m_prev = s; m_irq = irq_n; m_id = id_n;
            m_sq.push_back(16'(irq_src));
            void'(m_sq.pop_front());
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 16'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick(1'b0, 16'h0);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick(1'b0, 16'h0);
        chipselect = 1'b0;
    endtask

    // Read whose expected value is a fixed number worked out from the rules.
    task automatic rdc(input logic [2:0] a, input logic [15:0] e);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        tick(1'b1, e);
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        chipselect = 1'b0; write_n = 1'b1;
        idle(1);
        reset_n = 1'b0;
        model_reset();
        sb.delete();
        idle(2);
        reset_n = 1'b1;
    endtask

    // Read-valid tracker: the DUT presents read data the cycle after a read.
    initial forever begin
        @(posedge clk);
        rd_seen = reset_n && chipselect && write_n;
    end

    // Monitor: checks irq/irq_id every cycle and pops read expectations.
    initial forever begin
        logic [15:0] exp;
        @(negedge clk);
        vectors++;
        if (irq !== m_irq) begin
            miscompares++;
            $display("FAIL irq t=%0t got=%0b exp=%0b", $time, irq, m_irq);
        end
        vectors++;
        if (irq_id !== m_id) begin
            miscompares++;
            $display("FAIL irq_id t=%0t got=%h exp=%h", $time, irq_id, m_id);
        end
        if (rd_seen) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_empty t=%0t got=%h exp=none", $time, readdata);
            end else begin
                exp = sb.pop_front();
                if (readdata !== exp) begin
                    miscompares++;
                    $display("FAIL readdata t=%0t got=%h exp=%h", $time, readdata, exp);
                end else begin
                    $display("read ok t=%0t data=%h", $time, readdata);
                end
            end
        end
    end

    initial begin
        model_reset();
        idle(3);
        reset_n = 1'b1;
        idle(2);
        rdc(3'd0, 16'h0000);
        rdc(3'd4, 16'h000F);

        // Edge-mode timer source
        wr(3'd1, 16'h0001);
        wr(3'd2, 16'h0001);
        irq_src = 8'h01; idle(1); irq_src = 8'h00;
        idle(5);
        rdc(3'd4, 16'h8000);
        wr(3'd0, 16'h0001);
        rdc(3'd0, 16'h0000);

        // Priority between two simultaneous edges
        wr(3'd1, 16'h00FF);
        wr(3'd2, 16'h00FF);
        irq_src = 8'h24; idle(1); irq_src = 8'h00;
        idle(5);
        rdc(3'd4, 16'h8002);
        wr(3'd0, 16'h0004);
        idle(2);
        rdc(3'd4, 16'h8005);
        wr(3'd0, 16'h0020);

        // Level source: clear blocked while high
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0008);
        irq_src = 8'h08; idle(4);
        wr(3'd0, 16'h0008);
        rdc(3'd0, 16'h0008);
        irq_src = 8'h00; idle(3);
        wr(3'd0, 16'h0008);
        idle(2);
        rdc(3'd0, 16'h0000);
        rdc(3'd4, 16'h000F);

        // Masked edge still pends; unmask raises irq
        wr(3'd1, 16'h0000);
        wr(3'd2, 16'h0002);
        irq_src = 8'h02; idle(1); irq_src = 8'h00;
        idle(4);
        rdc(3'd0, 16'h0002);
        wr(3'd1, 16'h0002);
        idle(2);
        rdc(3'd4, 16'h8001);
        wr(3'd0, 16'h0002);

        // Force, counter, set-wins-over-clear
        do_reset();
        wr(3'd5, 16'h0010);
        wr(3'd5, 16'h0030);
        rdc(3'd0, 16'h0030);
        rdc(3'd6, CNT_AFTER_TWO);
        rdc(3'd5, 16'h0000);
        irq_src = 8'h10; idle(4);
        wr(3'd0, 16'h0010);
        rdc(3'd0, 16'h0030);
        irq_src = 8'h00; idle(3);
        wr(3'd0, 16'h0030);
        wr(3'd6, 16'h1234);
        rdc(3'd6, 16'h0000);
        rdc(3'd0, 16'h0000);

        // Reset mid-operation with irq asserted
        wr(3'd2, 16'h0001);
        wr(3'd1, 16'h0001);
        irq_src = 8'h01; idle(6);
        do_reset();
        idle(4);
        rdc(3'd1, 16'h0000);
        rdc(3'd2, 16'h0000);
        rdc(3'd0, 16'h0001);
        rdc(3'd4, 16'h000F);
        irq_src = 8'h00; idle(3);
        wr(3'd0, 16'hFFFF);

        // Randomised traffic
        for (int it = 0; it < 800; it++) begin
            int op;
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
            if (it == 400) do_reset();
            else if (op <= 2) rd(3'($urandom_range(0, 7)));
            else if (op <= 4) wr(3'($urandom_range(0, 7)), 16'($urandom));
            else if (op == 5) wr(3'd0, 16'($urandom));
            else if (op == 6) wr(3'd1, 16'($urandom));
            else idle(1);
        end
        irq_src = '0;
        idle(3);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
